pa_bmu_dbus_reqq: RTL
=====================

Name: pa_bmu_dbus_reqq

Overview:
- Data-bus request queue between the LSU and the dbus request port of the instruction-side AHB-Lite interface (pa_iahbl_top).
- Accepts LSU load/store requests into a small FIFO and presents the head entry on the bmu_iahbl_dbus_* request port.
- Counts outstanding granted transfers and returns completions, read data and errors to the LSU.
- On lsu_xx_flush it drops all queued requests and discards the completions of transfers already granted.

Parameters:
- QDEPTH, 2, request FIFO entries; legal values 2 or 4 only (power of two).
- MAX_OSTD, 2, maximum granted-but-not-completed transfers; 1 to 3.

Ports:
- forever_cpuclk  in  1  clock
- cpurst_b  in  1  reset, synchronous, active-low
- lsu_bmu_req  in  1  LSU request valid
- lsu_bmu_addr  in  32  request address
- lsu_bmu_wdata  in  32  store data
- lsu_bmu_write  in  1  1 = store
- lsu_bmu_size  in  2  0 = byte, 1 = half, 2 = word
- lsu_bmu_prot  in  4  HPROT attributes
- lsu_bmu_lock  in  1  locked access
- lsu_bmu_acc_deny  in  1  PMP deny; forwarded with the request
- lsu_xx_flush  in  1  pipeline flush
- bmu_lsu_grnt  out  1  request accepted this cycle
- bmu_lsu_trans_cmplt  out  1  transfer complete
- bmu_lsu_data  out  32  read data; valid when bmu_lsu_trans_cmplt = 1
- bmu_lsu_acc_err  out  1  bus or deny error; valid when bmu_lsu_trans_cmplt = 1
- bmu_iahbl_dbus_req  out  1  head request valid
- bmu_iahbl_dbus_req_dp  out  1  copy of bmu_iahbl_dbus_req for the datapath
- bmu_iahbl_dbus_addr / wdata / write / size / prot / lock / acc_deny  out  32/32/1/2/4/1/1  head entry fields
- bmu_iahbl_dbus_burst  out  3  constant 3'b000
- bmu_iahbl_dbus_seq  out  1  constant 0
- bmu_iahbl_dbus_lrsc  out  1  constant 0
- iahbl_bmu_dbus_grnt  in  1  head accepted by the interface
- iahbl_bmu_dbus_trans_cmplt  in  1  oldest outstanding transfer done
- iahbl_bmu_dbus_data  in  32  read data
- iahbl_bmu_dbus_acc_err  in  1  error response
- bmu_dbus_idle  out  1  queue empty, no outstanding transfers and no pending discards

Behaviour:
- All state resets on the rising forever_cpuclk edge while cpurst_b = 0.
- Reset values: FIFO empty, read and write pointers 0, outstanding count 0, discard count 0. Therefore req, req_dp, grnt and trans_cmplt = 0 and bmu_dbus_idle = 1. Queue payload registers are not reset; their outputs are don't-care while req = 0.
- Accept condition: bmu_lsu_grnt = lsu_bmu_req & ~lsu_xx_flush & (count < QDEPTH).
  - count is the registered value, so a full queue does not accept a request even if a pop happens in the same cycle.
- Push: on bmu_lsu_grnt, all fields are written into entry wptr and wptr advances modulo QDEPTH.
- Issue condition: bmu_iahbl_dbus_req = fifo_not_empty & (ostd < MAX_OSTD) & ~discard_pending_block.
  - discard_pending_block = 0; issue never waits on pending discards.
- The bmu_iahbl_dbus_* request fields are driven from entry rptr through combinational muxing only.
- Once req = 1, the request stays asserted with stable fields until granted. A flush is the only thing that can withdraw it.
- Pop: on iahbl_bmu_dbus_grnt & req, rptr advances and ostd increments.
  - A grant while req = 0 is ignored and flagged by an assertion.
- Completion: iahbl_bmu_dbus_trans_cmplt decrements ostd (same cycle as any increment; net change +1, 0 or -1).
  - If discard > 0: the completion is dropped, bmu_lsu_trans_cmplt = 0 and discard decrements.
  - Otherwise: bmu_lsu_trans_cmplt = 1, and bmu_lsu_data and bmu_lsu_acc_err pass through combinationally. Latency is 0 cycles from the interface.
- Flush (lsu_xx_flush = 1):
  - Next cycle: FIFO empty (wptr = rptr = 0).
  - discard <= ostd_next + discard_next, where ostd_next includes a grant taken in the flush cycle.
  - A completion arriving in the flush cycle is forwarded to the LSU only if discard was 0 before the flush.
  - ostd is not cleared; the granted transfers still finish on the bus.
- Ordering: completions are in order and correspond one-to-one with grants.
- Width limits: ostd and discard saturate at MAX_OSTD. A completion while ostd = 0 is illegal and flagged by an assertion.
- bmu_dbus_idle = (count == 0) & (ostd == 0) & (discard == 0); registered-state based.

Test Plan:
- Reset → after cpurst_b = 0 for one clock: req = 0, grnt = 0, trans_cmplt = 0, idle = 1.
- Single load, addr 0x2000_0010, size 2 → grnt in cycle 0; req with addr 0x2000_0010 in cycle 1. Interface grnt in cycle 1 → ostd = 1. Interface cmplt in cycle 3 with data 0xDEAD_BEEF → bmu_lsu_trans_cmplt = 1, data 0xDEAD_BEEF, idle = 1 in cycle 4.
- Backpressure: 3 back-to-back stores with interface grnt held at 0 → first two granted, third sees grnt = 0 while count = 2. Req stays asserted with the first entry's addr/wdata stable. A single interface grnt lets the third be accepted the following cycle.
- MAX_OSTD limit: two grants with no completions → req drops to 0 with a third entry queued. One cmplt → req reasserts the next cycle.
- Flush with 1 outstanding and 1 queued, grnt in the flush cycle → queue empty next cycle, discard = 2. Next two cmplt pulses are not forwarded (trans_cmplt = 0), then idle = 1.
- Error: cmplt with iahbl acc_err = 1 → bmu_lsu_acc_err = 1 in the same cycle. The LSU request with acc_deny = 1 shows bmu_iahbl_dbus_acc_deny = 1 at issue.

Source files
------------

// File: rtl/pa_bmu_dbus_reqq.sv
// Data-bus request queue between the LSU and the iahbl dbus port. It holds a small
// request FIFO, counts outstanding transfers and drops the completions that follow a flush.
module pa_bmu_dbus_reqq #(
  parameter int QDEPTH   = 2,
  parameter int MAX_OSTD = 2
) (
  input  logic        forever_cpuclk,
  input  logic        cpurst_b,
  input  logic        lsu_bmu_req,
  input  logic [31:0] lsu_bmu_addr,
  input  logic [31:0] lsu_bmu_wdata,
  input  logic        lsu_bmu_write,
  input  logic [1:0]  lsu_bmu_size,
  input  logic [3:0]  lsu_bmu_prot,
  input  logic        lsu_bmu_lock,
  input  logic        lsu_bmu_acc_deny,
  input  logic        lsu_xx_flush,
  output logic        bmu_lsu_grnt,
  output logic        bmu_lsu_trans_cmplt,
  output logic [31:0] bmu_lsu_data,
  output logic        bmu_lsu_acc_err,
  output logic        bmu_iahbl_dbus_req,
  output logic        bmu_iahbl_dbus_req_dp,
  output logic [31:0] bmu_iahbl_dbus_addr,
  output logic [31:0] bmu_iahbl_dbus_wdata,
  output logic        bmu_iahbl_dbus_write,
  output logic [1:0]  bmu_iahbl_dbus_size,
  output logic [3:0]  bmu_iahbl_dbus_prot,
  output logic        bmu_iahbl_dbus_lock,
  output logic        bmu_iahbl_dbus_acc_deny,
  output logic [2:0]  bmu_iahbl_dbus_burst,
  output logic        bmu_iahbl_dbus_seq,
  output logic        bmu_iahbl_dbus_lrsc,
  input  logic        iahbl_bmu_dbus_grnt,
  input  logic        iahbl_bmu_dbus_trans_cmplt,
  input  logic [31:0] iahbl_bmu_dbus_data,
  input  logic        iahbl_bmu_dbus_acc_err,
  output logic        bmu_dbus_idle
);

  localparam int          PW      = (QDEPTH > 2) ? 2 : 1;
  localparam logic [2:0]  DEPTH_C = 3'(QDEPTH);
  localparam logic [1:0]  MAX_C   = 2'(MAX_OSTD);

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  size;
    logic [3:0]  prot;
    logic        lock;
    logic        acc_deny;
  } entry_t;

  entry_t          fifo_q [QDEPTH];
  entry_t          head;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [2:0]      count_q, count_next;
  logic [1:0]      ostd_q, ostd_next;
  logic [1:0]      disc_q, disc_next, disc_dec;
  logic [2:0]      ostd_sum, disc_sum;
  logic            push, pop, issue, disc_hit;

  assign push     = lsu_bmu_req & ~lsu_xx_flush & (count_q < DEPTH_C);
  assign issue    = (count_q != '0) & (ostd_q < MAX_C);
  assign pop      = iahbl_bmu_dbus_grnt & issue;
  assign disc_hit = iahbl_bmu_dbus_trans_cmplt & (disc_q != '0);
  assign head     = fifo_q[rptr_q];

  // Flush converts every transfer still owed by the bus, including one granted
  // in the flush cycle, into a completion that must be swallowed.
  always_comb begin
    ostd_sum = 3'(ostd_q) + 3'(pop);
    if (iahbl_bmu_dbus_trans_cmplt && (ostd_sum != '0))
      ostd_sum = ostd_sum - 3'd1;
    ostd_next = (ostd_sum > 3'(MAX_C)) ? MAX_C : ostd_sum[1:0];

    disc_dec  = disc_q - 2'(disc_hit);
    disc_sum  = 3'(ostd_next) + 3'(disc_dec);
    disc_next = disc_dec;
    if (lsu_xx_flush)
      disc_next = (disc_sum > 3'(MAX_C)) ? MAX_C : disc_sum[1:0];

    count_next = count_q + 3'(push) - 3'(pop);
    if (lsu_xx_flush)
      count_next = '0;
  end

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ostd_q  <= '0;
      disc_q  <= '0;
    end else begin
      count_q <= count_next;
      ostd_q  <= ostd_next;
      disc_q  <= disc_next;
      if (lsu_xx_flush) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PW'(1);
        if (pop)  rptr_q <= rptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (push) begin
      fifo_q[wptr_q] <= '{addr:     lsu_bmu_addr,
                          wdata:    lsu_bmu_wdata,
                          write:    lsu_bmu_write,
                          size:     lsu_bmu_size,
                          prot:     lsu_bmu_prot,
                          lock:     lsu_bmu_lock,
                          acc_deny: lsu_bmu_acc_deny};
    end
  end

  assign bmu_lsu_grnt            = push;
  assign bmu_lsu_trans_cmplt     = iahbl_bmu_dbus_trans_cmplt & (disc_q == '0);
  assign bmu_lsu_data            = iahbl_bmu_dbus_data;
  assign bmu_lsu_acc_err         = iahbl_bmu_dbus_acc_err;

  assign bmu_iahbl_dbus_req      = issue;
  assign bmu_iahbl_dbus_req_dp   = issue;
  assign bmu_iahbl_dbus_addr     = head.addr;
  assign bmu_iahbl_dbus_wdata    = head.wdata;
  assign bmu_iahbl_dbus_write    = head.write;
  assign bmu_iahbl_dbus_size     = head.size;
  assign bmu_iahbl_dbus_prot     = head.prot;
  assign bmu_iahbl_dbus_lock     = head.lock;
  assign bmu_iahbl_dbus_acc_deny = head.acc_deny;
  assign bmu_iahbl_dbus_burst    = 3'b000;
  assign bmu_iahbl_dbus_seq      = 1'b0;
  assign bmu_iahbl_dbus_lrsc     = 1'b0;

  assign bmu_dbus_idle = (count_q == '0) & (ostd_q == '0) & (disc_q == '0);

  a_grnt_without_req: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(iahbl_bmu_dbus_grnt && !bmu_iahbl_dbus_req));
  a_cmplt_without_ostd: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(iahbl_bmu_dbus_trans_cmplt && (ostd_q == '0)));

endmodule
